// File: rtl/qupls4_fpu_wb_buffer.sv
// Result FIFO between the meta FPU and the register-file writeback bus; drops stomped results.
// Optional same-cycle empty-queue bypass: define QUPLS4_FPU_WB_BYPASS_EN.
module qupls4_fpu_wb_buffer #(
   parameter int WID   = 64,
   parameter int DEPTH = 4,
   parameter int NROB  = 32,
   parameter int RNDXW = 5,
   parameter int AREGW = 8,
   parameter int EXCW  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NROB-1:0]            stomp,
   input  logic                       in_v,
   input  logic                       in_done,
   input  logic [RNDXW-1:0]           in_rndx,
   input  logic [AREGW-1:0]           in_aRd,
   input  logic [WID-1:0]             in_o,
   input  logic [WID/8:0]             in_we,
   input  logic [EXCW-1:0]            in_exc,
   output logic                       stall_o,
   output logic                       wb_v,
   input  logic                       wb_rdy,
   output logic [RNDXW-1:0]           wb_rndx,
   output logic [AREGW-1:0]           wb_aRd,
   output logic [WID-1:0]             wb_o,
   output logic [WID/8:0]             wb_we,
   output logic [EXCW-1:0]            wb_exc,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WEW = WID/8 + 1;
   localparam logic [AW:0] FULL_X = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [RNDXW-1:0] rndx;
      logic [AREGW-1:0] aRd;
      logic [WID-1:0]   o;
      logic [WEW-1:0]   we;
      logic [EXCW-1:0]  exc;
   } res_t;

   res_t             mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] dead_q, dead_d;
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             ovf_q, ovf_d;

   logic [AW-1:0]    wr_idx, rd_idx;
   logic             full, empty;
   res_t             in_res, head, wb_res;
   logic             head_vld, head_stomp, flush, fifo_v, byp;
   logic             push_att, push, pop;
   logic [DEPTH-1:0] push_oh, pop_oh;

   assign wr_idx = wr_q[AW-1:0];
   assign rd_idx = rd_q[AW-1:0];
   assign full   = (wr_q ^ rd_q) == FULL_X;
   assign empty  = (wr_q == rd_q);

   always_comb begin
      in_res      = '0;
      in_res.rndx = in_rndx;
      in_res.aRd  = in_aRd;
      in_res.o    = in_o;
      in_res.we   = in_we;
      in_res.exc  = in_exc;
   end

   // A head that is dead or stomped right now is flushed without waiting for wb_rdy.
   assign head       = mem_q[rd_idx];
   assign head_vld   = ~empty & vld_q[rd_idx];
   assign head_stomp = stomp[head.rndx];
   assign flush      = head_vld & (dead_q[rd_idx] | head_stomp);
   assign fifo_v     = head_vld & ~dead_q[rd_idx] & ~head_stomp;

   assign push_att = in_v & in_done & (|in_we) & ~stomp[in_rndx];

`ifdef QUPLS4_FPU_WB_BYPASS_EN
   assign byp = empty & push_att;
`else
   assign byp = 1'b0;
`endif

   assign wb_v    = fifo_v | byp;
   assign pop     = (fifo_v & wb_rdy) | flush;
   // When full, a push is still taken in the same cycle as a pop frees a slot.
   assign push    = push_att & (~full | pop) & ~(byp & wb_rdy);
   assign stall_o = full & ~pop;

   always_comb begin
      wb_res = '0;
      if (fifo_v)
         wb_res = head;
      else if (byp)
         wb_res = in_res;
   end

   assign wb_rndx = wb_res.rndx;
   assign wb_aRd  = wb_res.aRd;
   assign wb_o    = wb_res.o;
   assign wb_we   = wb_res.we;
   assign wb_exc  = wb_res.exc;

   assign count = wr_q - rd_q;
   assign ovf   = ovf_q;

   assign push_oh = push ? (DEPTH'(1) << wr_idx) : '0;
   assign pop_oh  = pop  ? (DEPTH'(1) << rd_idx) : '0;

   // Push is applied last so a full-queue push/pop to the same slot leaves it live.
   always_comb begin
      vld_d  = vld_q;
      dead_d = dead_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && stomp[mem_q[i].rndx])
            dead_d[i] = 1'b1;
         if (pop_oh[i]) begin
            vld_d[i]  = 1'b0;
            dead_d[i] = 1'b0;
         end
         if (push_oh[i]) begin
            vld_d[i]  = 1'b1;
            dead_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      wr_d  = wr_q + {{AW{1'b0}}, push};
      rd_d  = rd_q + {{AW{1'b0}}, pop};
      ovf_d = ovf_q | (push_att & full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         vld_q  <= '0;
         dead_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         vld_q  <= vld_d;
         dead_q <= dead_d;
         ovf_q  <= ovf_d;
      end
   end

   // Payload storage needs no reset; valid bits gate every read.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_idx] <= in_res;
   end

endmodule
